qwi12_key_capture: RTL
======================

Name: qwi12_key_capture

Overview:
- Input-direction companion to the PS GPIO LED output path: takes raw board push-buttons into the PL and delivers clean state and events to the PS GPIO input channel.
- Synchronises and debounces each key, then produces per-key press events.
- Latches each event until software clears it, and raises a level interrupt to the PS while any event is pending.

Parameters:
- KEY_NUM, 4, number of keys, 1..32.
- DEBOUNCE_CYC, 1000000, stable-sample count required to accept a level change (20 ms at 50 MHz FCLK). Minimum 2.
- KEY_ACTIVE_LOW, 1, 1 = pressed key reads 0 on key_in; 0 = pressed reads 1.

Ports:
- clk  input  1  PS fabric clock; all logic is on this edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_in  input  KEY_NUM  raw button pins, asynchronous to clk.
- key_level  output  KEY_NUM  debounced state, 1 = pressed; to GPIO input bits.
- key_press  output  KEY_NUM  one-cycle pulse per accepted press.
- evt_pend  output  KEY_NUM  sticky press-event flags; to GPIO input bits.
- evt_clr  input  KEY_NUM  from GPIO output bits, synchronous to clk; a rising edge on bit i clears evt_pend[i].
- irq  output  1  registered OR of evt_pend.

Behaviour:
- Reset (rst_n=0, async assert):
  - key_level, key_press, evt_pend and irq = 0.
  - Sync flops = released level; debounce counters = 0; evt_clr history = 0.
- Synchroniser:
  - 2-FF per bit, then polarity normalise (invert when KEY_ACTIVE_LOW=1), giving s[i] with 1 = pressed.
- Debounce, per key, independent:
  - When s[i] == key_level[i], the counter is cleared to 0.
  - When s[i] != key_level[i], the counter increments.
  - When the counter == DEBOUNCE_CYC-1 and s[i] still differs, key_level[i] toggles and the counter is cleared.
  - Counter width = $clog2(DEBOUNCE_CYC). The counter never wraps, because it clears on acceptance.
  - Any glitch shorter than DEBOUNCE_CYC cycles is rejected: the counter restarts on every bounce back.
- Latency:
  - A clean edge on key_in reaches key_level after 2 + DEBOUNCE_CYC clk cycles.
  - key_press asserts in the same cycle key_level rises 0->1, for exactly one cycle.
  - Release (1->0) produces no pulse.
- Event latch:
  - evt_pend[i] sets in the cycle after key_press[i].
  - evt_clr rising edge is detected against a registered copy; evt_pend[i] clears in the cycle after the rising edge.
  - evt_clr held high clears only once; a later press sets evt_pend again even while evt_clr stays high.
  - Simultaneous set and clear in the same cycle: set wins, so no event is lost.
- irq:
  - Registered OR of evt_pend, one cycle behind it.
  - Deasserts one cycle after the last pending bit clears.
- Key held through reset: after rst_n release, key_level reaches 1 after 2 + DEBOUNCE_CYC cycles and produces one key_press and one event.
- Reset asserted mid-debounce: all state is discarded immediately; the count restarts from 0 after release.
- Keys are fully independent; simultaneous presses on several keys set several evt_pend bits in the same cycle.

Decomposition:
- Package qwi12_key_pkg holds:
  - the default DEBOUNCE_CYC constant;
  - a helper function for counter width;
  - the simulation constant SIM_DEBOUNCE_CYC = 16.
- Sub-module qwi12_key_debounce handles one key: synchroniser, polarity, counter, key_level and key_press.
  - The top generates KEY_NUM instances.
  - The event latch, evt_clr edge detection and irq stay in qwi12_key_capture.

Test Plan (DEBOUNCE_CYC=16, KEY_ACTIVE_LOW=1, KEY_NUM=4):
1. Reset behaviour: rst_n=0 for 5 cycles with key_in=4'hF, then release -> all outputs 0 throughout; no events after 100 cycles.
2. Clean press: key_in[0] 1->0 held for 40 cycles -> key_level[0]=1 exactly 18 cycles after the edge; key_press[0] high 1 cycle; evt_pend[0]=1 next cycle; irq=1 one cycle later.
3. Bounce rejection: key_in[1] toggles with pulses of 10, 15 and 3 cycles, then low for 30 cycles -> only one key_press[1], 18 cycles after the final edge; key_level never glitches.
4. Clear handshake: with evt_pend=4'b0001, evt_clr[0] rises and stays high -> evt_pend[0]=0 next cycle and irq=0 one cycle later. A new press while evt_clr[0] is still high sets evt_pend[0] again.
5. Set/clear collision: align an evt_clr[2] rising edge with key_press[2] -> evt_pend[2] remains 1.
6. Held through reset and mid-debounce reset:
   - key_in[3]=0 during reset -> key_press[3] at cycle 18 after release.
   - Pulse rst_n low at cycle 10 of a debounce -> key_level stays 0 and the count restarts from 0.

Source files
------------

// File: rtl/qwi12_key_pkg.sv
// Shared constants and helpers for the push-button capture path.
// Imported by the per-key debouncer and the capture top level.
package qwi12_key_pkg;

    localparam int DEBOUNCE_CYC_DEFAULT = 1000000;
    localparam int SIM_DEBOUNCE_CYC     = 16;

    // Width of a counter that must reach cyc-1; never narrower than one bit.
    function automatic int cnt_width(input int cyc);
        if (cyc <= 2) begin
            return 1;
        end else begin
            return $clog2(cyc);
        end
    endfunction

endpackage

// File: rtl/qwi12_key_debounce.sv
// One key: 2-FF synchroniser, polarity normalisation, stability counter,
// debounced level and a single-cycle press pulse on each accepted 0->1.
module qwi12_key_debounce
    import qwi12_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEFAULT,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic          RELEASED = KEY_ACTIVE_LOW;

    logic          sync1_r;
    logic          sync2_r;
    logic          pressed_s;
    logic          differ_s;
    logic          accept_s;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;

    // Two-stage synchroniser, parked at the released pin level in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RELEASED;
            sync2_r <= RELEASED;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
        end
    end

    assign pressed_s = sync2_r ^ KEY_ACTIVE_LOW;

    // A change is accepted only once it has persisted for DEBOUNCE_CYC samples.
    always_comb begin
        differ_s = 1'b0;
        accept_s = 1'b0;
        if (pressed_s != level_r) begin
            differ_s = 1'b1;
            accept_s = (cnt_r == CNT_LAST);
        end else begin
            differ_s = 1'b0;
            accept_s = 1'b0;
        end
    end

    // Stability counter: restarts on every bounce back and on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (!differ_s || accept_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

    // Debounced level and press pulse, both updated on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            if (accept_s) begin
                level_r <= pressed_s;
            end else begin
                level_r <= level_r;
            end
            press_r <= accept_s & pressed_s;
        end
    end

    assign key_level = level_r;
    assign key_press = press_r;

endmodule

// File: rtl/qwi12_key_capture.sv
// Board push-buttons to PS GPIO: per-key debounce, sticky press events
// cleared by software edge on evt_clr, and a level interrupt while any pend.
module qwi12_key_capture
    import qwi12_key_pkg::*;
#(
    parameter int KEY_NUM        = 4,
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEFAULT,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] evt_pend,
    input  logic [KEY_NUM-1:0] evt_clr,
    output logic               irq
);

    logic [KEY_NUM-1:0] evt_clr_r;
    logic [KEY_NUM-1:0] clr_rise_s;
    logic [KEY_NUM-1:0] evt_pend_r;
    logic               irq_r;

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
        qwi12_key_debounce #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .key_raw  (key_in[g]),
            .key_level(key_level[g]),
            .key_press(key_press[g])
        );
    end

    assign clr_rise_s = evt_clr & ~evt_clr_r;

    // History of evt_clr for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_clr_r <= {KEY_NUM{1'b0}};
        end else begin
            evt_clr_r <= evt_clr;
        end
    end

    // Sticky event latch; a press in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_pend_r <= {KEY_NUM{1'b0}};
        end else begin
            evt_pend_r <= (evt_pend_r & ~clr_rise_s) | key_press;
        end
    end

    // Interrupt follows the pending flags by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |evt_pend_r;
        end
    end

    assign evt_pend = evt_pend_r;
    assign irq      = irq_r;

endmodule
